draw_scheduler: RTL and testbench

- Frame-paced sequencer that owns the vga_adapter pixel-write port and the sprite ROM read port.
- On each frame tick it clears the screen to a background colour, then draws up to NUM_SPR fixed-size sprites from ROM in slot order.
- Replaces ad-hoc gated-clock draw sequencing with one clean single-clock FSM.
- Sits between game logic (sprite positions, enables) and vga_adapter (x, y, colour, plot).

---
 rtl/draw_pkg.sv | 24 ++
 rtl/spr_pixel_pipe.sv | 52 +++++
 rtl/draw_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and defaults for the frame draw sequencer and its pixel pipeline.
// Screen and sprite geometry defaults match a 320x240 vga_adapter with 16x16 sprites.
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BG,
        ST_SPR_SETUP,
        ST_SPR_DRAW,
        ST_SPR_FLUSH,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_SPR = 4;
    localparam int DEF_SCR_W   = 320;
    localparam int DEF_SCR_H   = 240;
    localparam int DEF_SPR_W   = 16;
    localparam int DEF_SPR_H   = 16;

    localparam logic [11:0] TRANSP_COLOUR = 12'hF0F;
    localparam logic [11:0] BG_BLACK      = 12'h000;
    localparam logic [11:0] BG_GREY       = 12'h884;

endpackage

// File: rtl/spr_pixel_pipe.sv
// One-stage alignment of a sprite pixel position with synchronous ROM data,
// plus the screen clip and transparency test that decides whether to plot.
module spr_pixel_pipe
    import draw_pkg::*;
#(
    parameter int          SCR_W  = DEF_SCR_W,
    parameter int          SCR_H  = DEF_SCR_H,
    parameter logic [11:0] TRANSP = TRANSP_COLOUR
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        valid_in,
    input  logic [9:0]  x_in,
    input  logic [8:0]  y_in,
    input  logic [11:0] rom_q,
    output logic        plot,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [11:0] colour
);

    logic       valid_q, valid_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;

    always_comb begin
        valid_d = valid_in;
        x_d     = x_in;
        y_d     = y_in;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Position is kept one bit wider than the screen so sprites hanging off
    // the right/bottom edge compare as off-screen instead of wrapping.
    assign plot   = valid_q && (rom_q != TRANSP) &&
                    (x_q < 10'(SCR_W)) && (y_q < 9'(SCR_H));
    assign x      = x_q[8:0];
    assign y      = y_q[7:0];
    assign colour = rom_q;

endmodule

// File: rtl/draw_scheduler.sv
// Frame-paced draw sequencer: clears the screen to a background colour, then
// draws the enabled sprite slots from ROM in slot order (later slots on top).
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int          NUM_SPR = DEF_NUM_SPR,
    parameter int          SPR_W   = DEF_SPR_W,
    parameter int          SPR_H   = DEF_SPR_H,
    parameter int          SCR_W   = DEF_SCR_W,
    parameter int          SCR_H   = DEF_SCR_H,
    parameter logic [11:0] TRANSP  = TRANSP_COLOUR
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   frame_tick,
    input  logic [11:0]            bg_colour,
    input  logic [NUM_SPR-1:0]     spr_en,
    input  logic [9*NUM_SPR-1:0]   spr_x,
    input  logic [8*NUM_SPR-1:0]   spr_y,
    output logic [16:0]            rom_addr,
    input  logic [11:0]            rom_q,
    output logic [8:0]             vga_x,
    output logic [7:0]             vga_y,
    output logic [11:0]            vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int PIX_N  = SPR_W * SPR_H;
    localparam int PX_W   = $clog2(SPR_W);
    localparam int PIX_W  = $clog2(PIX_N);
    localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    state_t               state_q, state_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [PIX_W-1:0]     pix_q, pix_d;
    logic [8:0]           bg_x_q, bg_x_d;
    logic [7:0]           bg_y_q, bg_y_d;
    logic [11:0]          sh_bg_q, sh_bg_d;
    logic [NUM_SPR-1:0]   sh_en_q, sh_en_d;
    logic [9*NUM_SPR-1:0] sh_x_q, sh_x_d;
    logic [8*NUM_SPR-1:0] sh_y_q, sh_y_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    logic       cur_en;
    logic [8:0] cur_x;
    logic [7:0] cur_y;
    logic       last_slot;
    logic       pipe_valid_in;
    logic       pipe_plot;
    logic [8:0] pipe_x;
    logic [7:0] pipe_y;
    logic [11:0] pipe_colour;

    always_comb begin
        cur_en = 1'b0;
        cur_x  = '0;
        cur_y  = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_en = sh_en_q[i];
                cur_x  = sh_x_q[9*i +: 9];
                cur_y  = sh_y_q[8*i +: 8];
            end
        end
    end

    assign last_slot = (slot_q == SLOT_W'(NUM_SPR - 1));

    spr_pixel_pipe #(
        .SCR_W  (SCR_W),
        .SCR_H  (SCR_H),
        .TRANSP (TRANSP)
    ) u_pipe (
        .clk      (clk),
        .reset_b  (reset_b),
        .valid_in (pipe_valid_in),
        .x_in     (10'(cur_x) + 10'(pix_q[PX_W-1:0])),
        .y_in     (9'(cur_y) + 9'(pix_q[PIX_W-1:PX_W])),
        .rom_q    (rom_q),
        .plot     (pipe_plot),
        .x        (pipe_x),
        .y        (pipe_y),
        .colour   (pipe_colour)
    );

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        pix_d         = pix_q;
        bg_x_d        = bg_x_q;
        bg_y_d        = bg_y_q;
        sh_bg_d       = sh_bg_q;
        sh_en_d       = sh_en_q;
        sh_x_d        = sh_x_q;
        sh_y_d        = sh_y_q;
        busy_d        = busy_q;
        overrun_d     = frame_tick && (state_q != ST_IDLE);
        rom_addr      = '0;
        pipe_valid_in = 1'b0;
        vga_x         = '0;
        vga_y         = '0;
        vga_colour    = '0;
        vga_plot      = 1'b0;
        frame_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    sh_bg_d = bg_colour;
                    sh_en_d = spr_en;
                    sh_x_d  = spr_x;
                    sh_y_d  = spr_y;
                    busy_d  = 1'b1;
                    bg_x_d  = '0;
                    bg_y_d  = '0;
                    slot_d  = '0;
                    state_d = ST_BG;
                end
            end
            ST_BG: begin
                vga_plot   = 1'b1;
                vga_x      = bg_x_q;
                vga_y      = bg_y_q;
                vga_colour = sh_bg_q;
                if (bg_x_q == 9'(SCR_W - 1)) begin
                    bg_x_d = '0;
                    if (bg_y_q == 8'(SCR_H - 1)) begin
                        slot_d  = '0;
                        state_d = ST_SPR_SETUP;
                    end else begin
                        bg_y_d = bg_y_q + 8'd1;
                    end
                end else begin
                    bg_x_d = bg_x_q + 9'd1;
                end
            end
            ST_SPR_SETUP: begin
                if (cur_en) begin
                    pix_d   = '0;
                    state_d = ST_SPR_DRAW;
                end else if (last_slot) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            ST_SPR_DRAW: begin
                rom_addr      = 17'(slot_q) * 17'(PIX_N) + 17'(pix_q);
                pipe_valid_in = 1'b1;
                vga_plot      = pipe_plot;
                vga_x         = pipe_x;
                vga_y         = pipe_y;
                vga_colour    = pipe_colour;
                if (pix_q == PIX_W'(PIX_N - 1)) begin
                    state_d = ST_SPR_FLUSH;
                end else begin
                    pix_d = pix_q + PIX_W'(1);
                end
            end
            ST_SPR_FLUSH: begin
                // The last issued address only has its ROM data now.
                vga_plot   = pipe_plot;
                vga_x      = pipe_x;
                vga_y      = pipe_y;
                vga_colour = pipe_colour;
                if (last_slot) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d  = slot_q + SLOT_W'(1);
                    state_d = ST_SPR_SETUP;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            pix_q     <= '0;
            bg_x_q    <= '0;
            bg_y_q    <= '0;
            sh_bg_q   <= '0;
            sh_en_q   <= '0;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            pix_q     <= pix_d;
            bg_x_q    <= bg_x_d;
            bg_y_q    <= bg_y_d;
            sh_bg_q   <= sh_bg_d;
            sh_en_q   <= sh_en_d;
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler on a reduced screen: a reference model fills
// an expected plot queue per frame, and every DUT plot is popped and compared.
module tb_draw_scheduler;

    localparam int          NUM_SPR = 4;
    localparam int          SPR_W   = 16;
    localparam int          SPR_H   = 16;
    localparam int          SCR_W   = 64;
    localparam int          SCR_H   = 48;
    localparam logic [11:0] TRANSP  = 12'hF0F;
    localparam int          SPR_PIX = SPR_W * SPR_H;
    localparam int          XW      = 9 * NUM_SPR;
    localparam int          YW      = 8 * NUM_SPR;

    logic               clk = 1'b0;
    logic               reset_b = 1'b0;
    logic               frame_tick = 1'b0;
    logic [11:0]        bg_colour = '0;
    logic [NUM_SPR-1:0] spr_en = '0;
    logic [XW-1:0]      spr_x = '0;
    logic [YW-1:0]      spr_y = '0;
    logic [16:0]        rom_addr;
    logic [11:0]        rom_q = '0;
    logic [8:0]         vga_x;
    logic [7:0]         vga_y;
    logic [11:0]        vga_colour;
    logic               vga_plot;
    logic               busy;
    logic               frame_done;
    logic               overrun;

    logic [11:0] rom [0:NUM_SPR*SPR_PIX-1];
    logic [28:0] exp_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          plot_cnt = 0;
    int          hi_addr_cnt = 0;
    int          ovr_cnt = 0;
    logic [16:0] last_xy = '0;

    draw_scheduler #(
        .NUM_SPR (NUM_SPR),
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .SCR_W   (SCR_W),
        .SCR_H   (SCR_H),
        .TRANSP  (TRANSP)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .frame_tick (frame_tick),
        .bg_colour  (bg_colour),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // ---------------- clock and synchronous ROM ----------------
    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr[9:0]];

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_b) begin
            if (overrun) ovr_cnt++;
            if (rom_addr >= 17'd256 && rom_addr < 17'd512) hi_addr_cnt++;
            if (vga_plot) begin
                plot_cnt++;
                last_xy = {vga_x, vga_y};
                vectors++;
                assert (exp_q.size() > 0) else begin
                    miscompares++;
                    $error("FAIL extra_plot: got x=%0d y=%0d c=%h expected no plot",
                           vga_x, vga_y, vga_colour);
                end
                if (exp_q.size() > 0) check("plot", {3'b0, vga_x, vga_y, vga_colour}, {3'b0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic build_expected(output int model_cnt, output int lat);
        int xx, yy;
        logic [11:0] c;
        exp_q.delete();
        for (int y = 0; y < SCR_H; y++)
            for (int x = 0; x < SCR_W; x++)
                exp_q.push_back({9'(x), 8'(y), bg_colour});
        lat = SCR_W * SCR_H + 2;
        for (int s = 0; s < NUM_SPR; s++) begin
            if (spr_en[s]) begin
                lat += SPR_PIX + 2;
                for (int py = 0; py < SPR_H; py++) begin
                    for (int px = 0; px < SPR_W; px++) begin
                        c  = rom[s * SPR_PIX + py * SPR_W + px];
                        xx = int'(spr_x[9*s +: 9]) + px;
                        yy = int'(spr_y[8*s +: 8]) + py;
                        if (c != TRANSP && xx < SCR_W && yy < SCR_H)
                            exp_q.push_back({9'(xx), 8'(yy), c});
                    end
                end
            end else begin
                lat += 1;
            end
        end
        model_cnt = exp_q.size();
    endtask

    // ---------------- frame driver ----------------
    task automatic run_frame(input string tag, input int exp_plots, input int ovr_at, input int rst_at);
        int   model_cnt, lat, n, exp_hi;
        logic done, aborted;
        build_expected(model_cnt, lat);
        exp_hi      = spr_en[1] ? SPR_PIX : 0;
        plot_cnt    = 0;
        hi_addr_cnt = 0;
        ovr_cnt     = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        // Inputs wander after acceptance; the frame must use the snapshot.
        bg_colour = 12'($urandom);
        spr_en    = NUM_SPR'($urandom);
        spr_x     = XW'({$urandom, $urandom});
        spr_y     = YW'({$urandom, $urandom});
        n = 0;
        done = 1'b0;
        aborted = 1'b0;
        while (!done && !aborted && n < lat + 50) begin
            @(negedge clk);
            if (n == 0) check({tag, "_busy_set"}, 32'(busy), 32'd1);
            if (frame_done) begin
                done = 1'b1;
            end else if (n == rst_at) begin
                @(posedge clk);
                #2;
                reset_b = 1'b0;
                #1;
                check({tag, "_rst_plot"}, 32'(vga_plot), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_addr"}, 32'(rom_addr), 32'd0);
                exp_q.delete();
                @(negedge clk);
                reset_b = 1'b1;
                aborted = 1'b1;
            end else begin
                frame_tick = (n == ovr_at);
                @(posedge clk);
                n++;
            end
        end
        frame_tick = 1'b0;
        if (!aborted) begin
            check({tag, "_done_seen"}, 32'(done), 32'd1);
            check({tag, "_latency"}, 32'(n + 2), 32'(lat));
            check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
            check({tag, "_plots_model"}, 32'(plot_cnt), 32'(model_cnt));
            if (exp_plots >= 0) check({tag, "_plots"}, 32'(plot_cnt), 32'(exp_plots));
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
            check({tag, "_overruns"}, 32'(ovr_cnt), (ovr_at >= 0) ? 32'd1 : 32'd0);
            check({tag, "_slot1_addrs"}, 32'(hi_addr_cnt), 32'(exp_hi));
            @(posedge clk);
            #1;
            check({tag, "_busy_clr"}, 32'(busy), 32'd0);
            check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
        end
    endtask

    task automatic set_slot(input int s, input int x, input int y);
        spr_x[9*s +: 9] = 9'(x);
        spr_y[8*s +: 8] = 8'(y);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [11:0] c;
        for (int i = 0; i < NUM_SPR * SPR_PIX; i++) begin
            c = 12'($urandom_range(0, 4095));
            if (i < SPR_PIX) c = 12'h0F0;
            else if (i < 2 * SPR_PIX && c == TRANSP) c = 12'h001;
            rom[i] = c;
        end

        reset_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_plot", 32'(vga_plot), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_addr", 32'(rom_addr), 32'd0);
        check("reset_xyc", {3'b0, vga_x, vga_y, vga_colour}, 32'd0);
        @(negedge clk);
        reset_b = 1'b1;

        bg_colour = 12'h884;
        spr_en    = '0;
        run_frame("bg_only", SCR_W * SCR_H, -1, -1);
        check("bg_last_xy", 32'(last_xy), 32'({9'(SCR_W - 1), 8'(SCR_H - 1)}));

        bg_colour = 12'h123;
        spr_en    = 4'b0001;
        set_slot(0, 20, 10);
        run_frame("slot0_full", SCR_W * SCR_H + 256, -1, -1);

        bg_colour = 12'h456;
        spr_en    = 4'b0010;
        set_slot(1, SCR_W - 10, SCR_H - 5);
        run_frame("slot1_clip", SCR_W * SCR_H + 50, -1, -1);

        rom[5]    = TRANSP;
        bg_colour = 12'h789;
        spr_en    = 4'b0001;
        set_slot(0, 0, 0);
        run_frame("transp", SCR_W * SCR_H + 255, -1, -1);

        bg_colour = 12'hABC;
        spr_en    = 4'b1111;
        for (int s = 0; s < NUM_SPR; s++)
            set_slot(s, $urandom_range(0, SCR_W + 8), $urandom_range(0, SCR_H + 8));
        run_frame("overrun", -1, 1000, -1);

        bg_colour = 12'h111;
        spr_en    = 4'b0001;
        set_slot(0, 5, 5);
        run_frame("abort", -1, -1, SCR_W * SCR_H + 100);

        bg_colour = 12'h222;
        spr_en    = 4'b1010;
        set_slot(1, 30, 20);
        set_slot(3, 36, 24);
        run_frame("after_reset", -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
